mem_bank_sched: RTL and testbench
=================================

MEM_BANK_SCHED -- requirements
Module: mem_bank_sched

Interface
REQ-001 SHALL have parameter REG_DEPTH, default 4, number of bank entries (power of two, >=2).
REQ-002 SHALL have parameter REG_WIDTH, default 64, data width in bits; AW = $clog2(REG_DEPTH).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk  in  1  sole clock, all state rising-edge.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have, per requester X in {a,b}: X_req_valid in 1; X_req_ready out 1; X_req_write in 1 (1=write, 0=read); X_req_addr in AW; X_req_wdata in REG_WIDTH.
REQ-006 SHALL have, per requester X: X_rsp_valid out 1; X_rsp_ready in 1; X_rsp_rdata out REG_WIDTH (read responses only).
REQ-007 SHALL drive the downstream 2RW bank, requester a on RW0 and requester b on RW1: RWn_clk out 1 (=clk); RWn_wmode out 1; RWn_addr out AW; RWn_wdata out REG_WIDTH; RWn_rdata in REG_WIDTH (combinational bank read).
REQ-008 SHALL have init_done out 1, high once zero-fill completes.
REQ-009 SHALL have conflict_cnt out 16, saturating count of conflict-stall cycles.

Function
REQ-010 SHALL run FSM states INIT, RUN; reset enters INIT with init pointer 0.
REQ-011 In INIT, SHALL drive RW0_wmode=1, RW0_addr=pointer, RW0_wdata=0, RW1_wmode=0, and increment pointer each cycle.
REQ-012 SHALL go INIT->RUN after the write to REG_DEPTH-1 (REG_DEPTH INIT cycles), set init_done the next cycle, and never return to INIT except via reset.
REQ-013 SHALL hold a_req_ready=b_req_ready=0 throughout INIT.
REQ-014 In RUN, a request on channel X SHALL be accepted (X_req_valid & X_req_ready) only if X's response slot is empty, or holds a response draining this cycle (X_rsp_valid & X_rsp_ready), and X is not losing a conflict.
REQ-015 Conflict SHALL mean: both valid, both eligible per REQ-014, equal addresses, and at least one write.
REQ-016 On conflict SHALL grant the channel selected by a round-robin bit (reset value: a), deassert the loser's ready, flip the bit after each conflict grant, and increment conflict_cnt (saturating at 16'hFFFF).
REQ-017 Non-conflicting requests (different addresses, or both reads) SHALL both be accepted in the same cycle.
REQ-018 For an accepted write, SHALL assert RWn_wmode=1 with addr/wdata from the request in the acceptance cycle; no response is generated.
REQ-019 For an accepted read, SHALL drive RWn_wmode=0, RWn_addr=request address, and capture RWn_rdata into X's response register at that clock edge; X_rsp_valid rises the following cycle (latency 1).
REQ-020 When a port is idle, SHALL hold RWn_wmode=0 and RWn_addr/wdata at their previous values.
REQ-021 X_rsp_valid/X_rsp_rdata SHALL remain stable until X_rsp_ready; back-to-back reads with rsp_ready=1 SHALL sustain one response per cycle.
REQ-022 X_req_ready SHALL not depend combinationally on X_req_valid (depends only on state, round-robin bit, rsp slot, rsp_ready, and the other channel's request).

Reset
REQ-023 Asserting rst_n low SHALL asynchronously clear: state=INIT, pointer=0, init_done=0, X_rsp_valid=0, X_rsp_rdata=0, round-robin=a, conflict_cnt=0; X_req_ready=0, RWn_wmode=0, RWn_addr=0, RWn_wdata=0.
REQ-024 Reset mid-RUN SHALL discard pending responses and restart the zero-fill sequence.

Structure
REQ-025 A shared package mem_pkg SHALL hold the FSM enum (INIT, RUN) and the conflict-counter width constant (16).
REQ-026 The per-channel response register SHALL be one sub-module, mem_rsp_slot, instantiated twice.

Verification
REQ-027 Reset release, REG_DEPTH=4 -> RW0_wmode=1 for 4 cycles at addr 0,1,2,3 with wdata 0; init_done=1 on cycle 5; ready low during INIT.
REQ-028 a writes 0xA5 to addr 2, next cycle b reads addr 2 -> b_rsp_valid one cycle later with rdata=0xA5.
REQ-029 a write addr 1 and b write addr 1 in the same cycle, twice in a row -> first a granted, then b; conflict_cnt=2; final entry = b's data.
REQ-030 a read addr 0, b read addr 0 simultaneously -> both accepted, conflict_cnt unchanged, both respond next cycle.
REQ-031 a issues 3 reads with a_rsp_ready=0 -> one accepted, a_req_ready stays low, a_rsp_rdata stable until a_rsp_ready=1.
REQ-032 rst_n low while a_rsp_valid=1 -> a_rsp_valid=0 immediately, INIT restarts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester bank scheduler.
package mem_pkg;
    typedef enum logic {INIT, RUN} state_e;
    localparam int CNT_W = 16;
endpackage

// File: rtl/mem_rsp_slot.sv
// One-entry read-response register: holds rdata until the requester takes it.
module mem_rsp_slot #(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] load_data,
    input  logic                 rsp_ready,
    output logic                 rsp_valid,
    output logic [REG_WIDTH-1:0] rsp_rdata
);
    // load is only raised when the slot is empty or draining this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_bank_sched.sv
// Schedules two requesters onto a 2RW bank: zero-fill on reset, then
// round-robin arbitration on same-address conflicts involving a write.
module mem_bank_sched
    import mem_pkg::*;
#(
    parameter int REG_DEPTH = 4,
    parameter int REG_WIDTH = 64,
    localparam int AW = $clog2(REG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req_valid,
    output logic                 a_req_ready,
    input  logic                 a_req_write,
    input  logic [AW-1:0]        a_req_addr,
    input  logic [REG_WIDTH-1:0] a_req_wdata,
    output logic                 a_rsp_valid,
    input  logic                 a_rsp_ready,
    output logic [REG_WIDTH-1:0] a_rsp_rdata,
    input  logic                 b_req_valid,
    output logic                 b_req_ready,
    input  logic                 b_req_write,
    input  logic [AW-1:0]        b_req_addr,
    input  logic [REG_WIDTH-1:0] b_req_wdata,
    output logic                 b_rsp_valid,
    input  logic                 b_rsp_ready,
    output logic [REG_WIDTH-1:0] b_rsp_rdata,
    output logic                 RW0_clk,
    output logic                 RW0_wmode,
    output logic [AW-1:0]        RW0_addr,
    output logic [REG_WIDTH-1:0] RW0_wdata,
    input  logic [REG_WIDTH-1:0] RW0_rdata,
    output logic                 RW1_clk,
    output logic                 RW1_wmode,
    output logic [AW-1:0]        RW1_addr,
    output logic [REG_WIDTH-1:0] RW1_wdata,
    input  logic [REG_WIDTH-1:0] RW1_rdata,
    output logic                 init_done,
    output logic [CNT_W-1:0]     conflict_cnt
);
    state_e               state_q, state_d;
    logic [AW-1:0]        ptr_q;
    logic                 init_done_q;
    logic                 rr_q;            // 0: a wins next conflict, 1: b
    logic [CNT_W-1:0]     cnt_q;
    logic [AW-1:0]        addr0_q, addr1_q;
    logic [REG_WIDTH-1:0] wdata0_q, wdata1_q;
    logic                 a_elig, b_elig, hit, conflict;
    logic                 a_acc, b_acc, rw0_act, rw1_act;
    logic                 init_last;

    assign RW0_clk      = clk;
    assign RW1_clk      = clk;
    assign init_done    = init_done_q;
    assign conflict_cnt = cnt_q;
    assign init_last    = (state_q == INIT) && (ptr_q == AW'(REG_DEPTH - 1));

    always_comb begin
        state_d   = state_q;
        a_elig    = (state_q == RUN) && (!a_rsp_valid || a_rsp_ready);
        b_elig    = (state_q == RUN) && (!b_rsp_valid || b_rsp_ready);
        hit       = (a_req_addr == b_req_addr) && (a_req_write || b_req_write);
        // ready looks only at the other side's valid, never its own
        a_req_ready = a_elig && !(b_req_valid && b_elig && hit && rr_q);
        b_req_ready = b_elig && !(a_req_valid && a_elig && hit && !rr_q);
        a_acc     = a_req_valid && a_req_ready;
        b_acc     = b_req_valid && b_req_ready;
        conflict  = a_req_valid && b_req_valid && a_elig && b_elig && hit;
        rw0_act   = 1'b0;
        rw1_act   = b_acc;
        RW0_wmode = 1'b0;
        RW0_addr  = addr0_q;
        RW0_wdata = wdata0_q;
        RW1_wmode = b_acc && b_req_write;
        RW1_addr  = b_acc ? b_req_addr : addr1_q;
        RW1_wdata = b_acc ? b_req_wdata : wdata1_q;
        if (state_q == INIT) begin
            rw0_act   = 1'b1;
            RW0_wmode = rst_n;
            RW0_addr  = ptr_q;
            RW0_wdata = '0;
            if (init_last) state_d = RUN;
        end else if (a_acc) begin
            rw0_act   = 1'b1;
            RW0_wmode = a_req_write;
            RW0_addr  = a_req_addr;
            RW0_wdata = a_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            wdata0_q    <= '0;
            wdata1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
            if (init_last) init_done_q <= 1'b1;
            if (conflict) begin
                rr_q <= ~rr_q;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            if (rw0_act) begin
                addr0_q  <= RW0_addr;
                wdata0_q <= RW0_wdata;
            end
            if (rw1_act) begin
                addr1_q  <= RW1_addr;
                wdata1_q <= RW1_wdata;
            end
        end
    end

    mem_rsp_slot #(.REG_WIDTH(REG_WIDTH)) u_slot_a (
        .clk(clk), .rst_n(rst_n), .load(a_acc && !a_req_write), .load_data(RW0_rdata),
        .rsp_ready(a_rsp_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata)
    );

    mem_rsp_slot #(.REG_WIDTH(REG_WIDTH)) u_slot_b (
        .clk(clk), .rst_n(rst_n), .load(b_acc && !b_req_write), .load_data(RW1_rdata),
        .rsp_ready(b_rsp_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata)
    );
endmodule

// File: tb/tb_mem_bank_sched.sv
// Randomized bench for mem_bank_sched against a transaction-level model.
module tb_mem_bank_sched;
    localparam int D  = 4;
    localparam int W  = 64;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
    logic          b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
    logic [AW-1:0] a_req_addr, b_req_addr, RW0_addr, RW1_addr;
    logic [W-1:0]  a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata;
    logic          RW0_clk, RW1_clk, RW0_wmode, RW1_wmode, init_done;
    logic [W-1:0]  RW0_wdata, RW1_wdata, RW0_rdata, RW1_rdata;
    logic [15:0]   conflict_cnt;

    mem_bank_sched #(.REG_DEPTH(D), .REG_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .RW0_clk(RW0_clk), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
        .RW1_clk(RW1_clk), .RW1_wmode(RW1_wmode), .RW1_addr(RW1_addr),
        .RW1_wdata(RW1_wdata), .RW1_rdata(RW1_rdata),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    // Behavioural 2RW bank; scramble loads junk so the zero-fill is visible
    logic [W-1:0] bank [D];
    bit scramble = 1'b1;
    assign RW0_rdata = bank[RW0_addr];
    assign RW1_rdata = bank[RW1_addr];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < D; i++) bank[i] <= 64'hBAD0_0000_0000_0000 | 64'(i + 1);
        end else begin
            if (RW0_wmode) bank[RW0_addr] <= RW0_wdata;
            if (RW1_wmode) bank[RW1_addr] <= RW1_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // stimulus for the current cycle, index 0 = a, 1 = b
    bit            iv[2], iw[2], irr[2];
    logic [AW-1:0] ia[2];
    logic [W-1:0]  id[2];

    // reference model
    bit            m_run, m_done, m_rr;
    int            m_ptr, m_cnt;
    bit            m_rv[2];
    logic [W-1:0]  m_rd[2], m_lw[2], ref_mem[D];
    logic [AW-1:0] m_la[2];

    task automatic model_reset();
        m_run = 0; m_done = 0; m_rr = 0; m_ptr = 0; m_cnt = 0;
        for (int x = 0; x < 2; x++) begin
            m_rv[x] = 0; m_rd[x] = '0; m_lw[x] = '0; m_la[x] = '0;
        end
    endtask

    task automatic put(input int x, input bit v, input bit w, input int a,
                       input logic [W-1:0] d, input bit r);
        iv[x] = v; iw[x] = w; ia[x] = AW'(a); id[x] = d; irr[x] = r;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, '0, 1);
        put(1, 0, 0, 0, '0, 1);
    endtask

    task automatic step();
        bit el[2], rdy[2], acc[2], gr[2], gw[2], gv[2], hit, both;
        logic [AW-1:0] ga[2];
        logic [W-1:0]  gd[2], gq[2], rv[2];
        a_req_valid = iv[0]; a_req_write = iw[0]; a_req_addr = ia[0];
        a_req_wdata = id[0]; a_rsp_ready = irr[0];
        b_req_valid = iv[1]; b_req_write = iw[1]; b_req_addr = ia[1];
        b_req_wdata = id[1]; b_rsp_ready = irr[1];
        #1;
        gr = '{a_req_ready, b_req_ready};  gv = '{a_rsp_valid, b_rsp_valid};
        gq = '{a_rsp_rdata, b_rsp_rdata};  gw = '{RW0_wmode, RW1_wmode};
        ga = '{RW0_addr, RW1_addr};        gd = '{RW0_wdata, RW1_wdata};
        acc = '{0, 0}; both = 0;
        if (!m_run) begin
            chk("init_rdy_a", 64'(gr[0]), 0);
            chk("init_rdy_b", 64'(gr[1]), 0);
            chk("init_wm0", 64'(gw[0]), 1);
            chk("init_addr0", 64'(ga[0]), 64'(m_ptr));
            chk("init_wd0", gd[0], 0);
            chk("init_wm1", 64'(gw[1]), 0);
        end else begin
            for (int x = 0; x < 2; x++) el[x] = !m_rv[x] || irr[x];
            hit  = (ia[0] == ia[1]) && (iw[0] || iw[1]);
            both = iv[0] && iv[1] && el[0] && el[1] && hit;
            for (int x = 0; x < 2; x++) begin
                // a channel loses only if the other is really contending and owns the turn
                rdy[x] = el[x] && !(iv[1-x] && el[1-x] && hit && (int'(m_rr) != x));
                acc[x] = iv[x] && rdy[x];
                chk(x ? "rdy_b" : "rdy_a", 64'(gr[x]), 64'(rdy[x]));
                chk(x ? "wm_b" : "wm_a", 64'(gw[x]), 64'(acc[x] && iw[x]));
                chk(x ? "addr_b" : "addr_a", 64'(ga[x]), 64'(acc[x] ? ia[x] : m_la[x]));
                if (!acc[x] || iw[x])
                    chk(x ? "wd_b" : "wd_a", gd[x], acc[x] ? id[x] : m_lw[x]);
            end
        end
        for (int x = 0; x < 2; x++) begin
            chk(x ? "rspv_b" : "rspv_a", 64'(gv[x]), 64'(m_rv[x]));
            chk(x ? "rspd_b" : "rspd_a", gq[x], m_rd[x]);
        end
        chk("init_done", 64'(init_done), 64'(m_done));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        if (!m_run) begin
            ref_mem[m_ptr] = '0; m_la[0] = AW'(m_ptr); m_lw[0] = '0;
            m_ptr++;
            if (m_ptr == D) begin m_run = 1; m_done = 1; end
        end else begin
            for (int x = 0; x < 2; x++) rv[x] = ref_mem[ia[x]];
            for (int x = 0; x < 2; x++) begin
                if (acc[x] && !iw[x]) begin m_rv[x] = 1; m_rd[x] = rv[x]; end
                else if (irr[x]) m_rv[x] = 0;
                if (acc[x]) begin
                    if (iw[x]) ref_mem[ia[x]] = id[x];
                    m_la[x] = ia[x]; m_lw[x] = id[x];
                end
            end
            if (both) begin
                m_rr = !m_rr;
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0; scramble = 1'b1;
        #1;
        chk("rst_rspv_a", 64'(a_rsp_valid), 0);
        chk("rst_rspv_b", 64'(b_rsp_valid), 0);
        chk("rst_rspd_a", a_rsp_rdata, 0);
        chk("rst_rdy_a", 64'(a_req_ready), 0);
        chk("rst_rdy_b", 64'(b_req_ready), 0);
        chk("rst_wm0", 64'(RW0_wmode), 0);
        chk("rst_wm1", 64'(RW1_wmode), 0);
        chk("rst_addr0", 64'(RW0_addr), 0);
        chk("rst_addr1", 64'(RW1_addr), 0);
        chk("rst_wd0", RW0_wdata, 0);
        chk("rst_done", 64'(init_done), 0);
        chk("rst_cnt", 64'(conflict_cnt), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; scramble = 1'b0;
    endtask

    task automatic rand_steps(input int n);
        for (int k = 0; k < n; k++) begin
            for (int x = 0; x < 2; x++)
                put(x, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, D - 1), {$urandom, $urandom}, $urandom_range(0, 9) < 7);
            step();
        end
    endtask

    initial begin
        idle();
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        @(posedge clk);
        #1;
        do_reset();
        repeat (D + 1) step();                       // zero-fill then first RUN cycle
        put(0, 1, 1, 2, 64'hA5, 1); step();          // a writes A5 to addr 2
        idle(); put(1, 1, 0, 2, '0, 1); step();      // b reads addr 2
        idle(); step();                              // b response visible here
        put(0, 1, 1, 1, 64'h1111, 1); put(1, 1, 1, 1, 64'h2222, 1);
        step(); step();                              // two conflicts: a then b
        idle(); step();
        chk("cc_two", 64'(conflict_cnt), 2);
        put(0, 1, 0, 1, '0, 1); put(1, 1, 0, 1, '0, 1); step();  // both read addr 1
        idle(); step();
        chk("final_entry", a_rsp_rdata, 64'h2222);
        put(0, 1, 0, 0, '0, 0); step(); step(); step();           // held response
        put(0, 0, 0, 0, '0, 1); step(); idle(); step();
        rand_steps(1500);
        idle(); put(0, 1, 0, 3, '0, 0); step();       // leave a response pending
        idle(); irr[0] = 0; step();
        do_reset();
        rand_steps(1500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
